// File: rtl/muldiv_unit.sv
// Iterative multiply / multiply-accumulate / divide engine for the EX stage.
// Latency: multiply MUL_LAT+1 cycles start-to-done, divide WIDTH+2 cycles.
// Backpressure: stall held from accepted start through FIX; starts outside IDLE are dropped.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic [2*WIDTH-1:0]   hilo_in,
    input  logic                 flush,
    output logic                 busy,
    output logic                 stall,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0]           state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;      // multiplicand, or dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]     b_q;      // multiplier or divisor magnitude
    logic [WIDTH-1:0]     rem_q;
    logic [2*WIDTH-1:0]   hilo_q;
    logic                 q_neg, r_neg;

    logic                 accept, is_div, signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   ext_a, ext_b, prod, mul_res;
    logic [WIDTH:0]       trial;
    logic                 ge;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     q_fix, r_fix;

    assign accept    = start & ~flush & (state == S_IDLE);
    assign is_div    = (op[2:1] == 2'b01);
    assign signed_op = ~op[0];
    assign a_mag     = (signed_op & num1[WIDTH-1]) ? -num1 : num1;
    assign b_mag     = (signed_op & num2[WIDTH-1]) ? -num2 : num2;

    assign stall  = (start & (state == S_IDLE) & ~flush) | busy;
    assign done   = (state == S_DONE);

    // Full 2*WIDTH product; truncation gives the modulo result for both signednesses.
    assign ext_a = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign ext_b = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod  = ext_a * ext_b;

    always_comb begin
        mul_res = prod;
        case (op_q[2:1])
            2'b10:   mul_res = hilo_q + prod;
            2'b11:   mul_res = hilo_q - prod;
            default: mul_res = prod;
        endcase
    end

    // Restoring step; a zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
    assign trial   = {rem_q, a_q[WIDTH-1]};
    assign ge      = (trial >= {1'b0, b_q});
    assign rem_nxt = ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];

    assign q_fix = q_neg ? -a_q : a_q;
    assign r_fix = r_neg ? -rem_q : rem_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = is_div ? S_DIV : S_MUL;
            S_MUL:  if (cnt == '0) state_nxt = S_DONE;
            S_DIV:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            hilo_q <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_MUL) || (state_nxt == S_DIV) || (state_nxt == S_FIX);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        hilo_q <= hilo_in;
                        rem_q  <= '0;
                        if (is_div) begin
                            a_q   <= a_mag;
                            b_q   <= b_mag;
                            q_neg <= signed_op & (num1[WIDTH-1] ^ num2[WIDTH-1]);
                            r_neg <= signed_op & num1[WIDTH-1];
                            cnt   <= CW'(WIDTH - 1);
                        end else begin
                            a_q   <= num1;
                            b_q   <= num2;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            cnt   <= CW'(MUL_LAT - 1);
                        end
                    end
                end
                S_MUL: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!flush) result <= mul_res;
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    a_q   <= {a_q[WIDTH-2:0], ge};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (!flush) result <= {r_fix, q_fix};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the EX stage. It supersedes the single-function divider and the combinational multiply paths with one iterative engine behind a start/done handshake. It supports signed and unsigned multiply, multiply-accumulate and multiply-subtract against HI/LO, and signed and unsigned divide. It drives a pipeline stall while busy and accepts a flush that aborts in-flight work.

## Interface
Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.
- MUL_LAT, 2, multiply latency in busy cycles (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- num1  in  WIDTH  multiplicand / dividend.
- num2  in  WIDTH  multiplier / divisor.
- hilo_in  in  2*WIDTH  accumulator for MADD/MSUB, sampled at start.
- flush  in  1  abort the in-flight operation.
- busy  out  1  operation in progress (MUL/DIV/FIX states).
- stall  out  1  combinational pipeline hold.
- done  out  1  one-cycle completion pulse.
- result  out  2*WIDTH  {hi, lo}; held between completions.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start & ~flush latches op, num1, num2 and hilo_in.
  - Multiply-class ops go to MUL; DIV/DIVU go to DIV.
- MUL:
  - Down-counter loaded with MUL_LAT-1; leave for DONE when it reaches 0.
  - Product is formed from the latched operands: signed×signed for even ops, unsigned×unsigned for odd ops.
  - MULT/MULTU: result = product.
  - MADD*: result = hilo_in + product.
  - MSUB*: result = hilo_in − product.
  - All arithmetic is modulo 2^(2*WIDTH).
- DIV: restoring division on magnitudes, one quotient bit per cycle for exactly WIDTH cycles, then FIX.
  - DIV takes magnitudes of both operands; DIVU uses them raw.
- FIX (1 cycle):
  - DIV: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - result = {remainder, quotient}.
- DONE: done=1 for one cycle, result valid; go to IDLE. A start in DONE is ignored; the pipeline re-presents it in IDLE.
- Divide by zero: no exception. Quotient = all ones, remainder = dividend (signed DIV applies FIX sign rules to the magnitudes). Latency is unchanged.
- Signed most-negative ÷ −1: quotient = most-negative, remainder = 0; no overflow flag.
- start while not IDLE: ignored; latched operands are unaffected.
- flush, any state:
  - Next state IDLE; no done for the aborted operation.
  - result is unchanged.
  - flush has priority over a same-cycle start.
- stall = (start & IDLE & ~flush) | busy. It is deasserted in DONE, so the pipeline advances in the cycle done is high.
- rst: state IDLE, counters 0, result 0, busy 0, done 0. rst has priority over flush and start, including mid-operation.

## Timing
- Start accepted at edge t (cycle 0 = start high in IDLE).
- Multiply: done high during cycle MUL_LAT+1 (cycle 3 with MUL_LAT=2).
- Divide: done high during cycle WIDTH+2 (cycle 34 with WIDTH=32).
- result updates at the edge entering DONE and holds until the next entry into DONE.
- Back-to-back: next start is accepted earliest in the cycle after DONE.
- busy is registered; stall is combinational from start, state and flush.

## Test plan
- MULT -3 × 5 (WIDTH=32, MUL_LAT=2) -> done in cycle 3, result=64'hFFFFFFFF_FFFFFFF1; MULTU 32'hFFFFFFFF × 2 -> 64'h00000001_FFFFFFFE.
- DIVU 100 / 7 -> done in cycle 34, result={32'd2, 32'd14}; stall high cycles 0–33, low in 34.
- DIV -7 / 2 -> {32'hFFFFFFFF, 32'hFFFFFFFD} (r=-1, q=-3); DIV 32'h80000000 / -1 -> {0, 32'h80000000}.
- DIVU 5 / 0 -> {32'd5, 32'hFFFFFFFF}; DIV -5 / 0 -> {32'hFFFFFFFB, 32'h00000001}.
- MADD hilo_in=64'h1_00000000, 3 × 4 -> 64'h1_0000000C; MSUBU hilo_in=0, 1 × 1 -> 64'hFFFFFFFF_FFFFFFFF.
- DIV started, flush in cycle 10 -> IDLE next cycle, no done, result unchanged.
  - A new MULT 2 × 3 in the following cycle -> 6 at cycle 3 relative.
  - A start asserted mid-DIV is ignored.
  - rst mid-MUL -> all outputs 0.
